clk_div_prog: RTL and testbench

- Runtime-programmable integer clock divider.
- Successor to the fixed-RATIO ring-counter divider: ratio width is parametrised, the ratio is reloaded at run time with a valid/ready handshake, and ratio changes take effect only at period boundaries.
- Adds glitch-free start/stop and a one-cycle tick per output period.
- Sits in the clock-generation area and feeds divided clocks / clock enables to downstream logic.

---
 rtl/clk_div_prog_if.sv | 24 ++
 rtl/clk_div_prog.sv | 125 ++++++++++++
 tb/tb_clk_div_prog.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_prog_if.sv
// Ratio reload channel for clk_div_prog.
// Ports: i_ratio/i_ratio_vld in, o_ratio_rdy/o_ratio_err back out.
interface clk_div_prog_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] i_ratio;
    logic             i_ratio_vld;
    logic             o_ratio_rdy;
    logic             o_ratio_err;

    modport master (
        output i_ratio,
        output i_ratio_vld,
        input  o_ratio_rdy,
        input  o_ratio_err
    );

    modport slave (
        input  i_ratio,
        input  i_ratio_vld,
        output o_ratio_rdy,
        output o_ratio_err
    );
endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with glitch-free start/stop.
// Ports: i_clk, i_rst (sync, high), i_en, rif (ratio channel),
//        o_clk, o_tick, o_active, o_ratio_cur.
module clk_div_prog #(
    parameter int WIDTH       = 8,
    parameter int RESET_RATIO = 9
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    clk_div_prog_if.slave    rif,
    output logic             o_clk,
    output logic             o_tick,
    output logic             o_active,
    output logic [WIDTH-1:0] o_ratio_cur
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP
    } state_e;

    localparam logic [WIDTH-1:0] RST_R = WIDTH'(RESET_RATIO);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO   = WIDTH'(2);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] ratio_q, ratio_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;

    logic             boundary;
    logic             accept;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] half_d;
    logic             run_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ratio_d    = ratio_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        err_d      = 1'b0;

        boundary = (state_q != IDLE) && (cnt_q == ratio_q - ONE);
        accept   = rif.i_ratio_vld && !pend_vld_q;
        cnt_inc  = boundary ? '0 : cnt_q + ONE;

        // Pending ratio lands on a period boundary, or at once when idle.
        if (pend_vld_q && (state_q == IDLE || boundary)) begin
            ratio_d    = pend_q;
            pend_vld_d = 1'b0;
        end

        // accept implies the slot was empty, so no clash with the above.
        if (accept) begin
            if (rif.i_ratio >= TWO) begin
                pend_d     = rif.i_ratio;
                pend_vld_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (i_en) state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_inc;
                if (!i_en) state_d = STOP;
            end
            STOP: begin
                cnt_d = cnt_inc;
                if (i_en) state_d = RUN;
                else if (boundary) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // (R+1)>>1 computed without needing a WIDTH+1 bit sum.
        half_d = (ratio_d >> 1) + {{(WIDTH-1){1'b0}}, ratio_d[0]};
        run_d  = (state_d != IDLE);
        clk_d  = run_d && (cnt_d < half_d);
        tick_d = run_d && (cnt_d == '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ratio_q    <= RST_R;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            clk_q      <= 1'b0;
            tick_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ratio_q    <= ratio_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            clk_q      <= clk_d;
            tick_q     <= tick_d;
            err_q      <= err_d;
        end
    end

    assign o_clk           = clk_q;
    assign o_tick          = tick_q;
    assign o_active        = (state_q != IDLE);
    assign o_ratio_cur     = ratio_q;
    assign rif.o_ratio_rdy = !pend_vld_q;
    assign rif.o_ratio_err = err_q;
endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog with a period-level reference model.
// Ports: none (top-level bench).
module tb_clk_div_prog;
    logic       clk;
    logic       rst;
    logic       en;
    logic       o_clk;
    logic       o_tick;
    logic       o_active;
    logic [7:0] o_ratio_cur;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 0;

    clk_div_prog_if #(.WIDTH(8)) rif ();

    clk_div_prog #(.WIDTH(8), .RESET_RATIO(9)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .rif         (rif),
        .o_clk       (o_clk),
        .o_tick      (o_tick),
        .o_active    (o_active),
        .o_ratio_cur (o_ratio_cur)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Reference model: a run of whole periods, each with its own ratio.
    // The block stops at a period end when i_en was low both in that
    // last cycle and in the cycle before it.
    bit m_run    = 0;
    int m_pos    = 0;
    int m_r      = 9;
    int m_pend   = 0;
    bit m_en_prv = 0;
    bit m_err    = 0;

    task automatic mdl_step();
        bit acc;
        int nr;
        if (rst) begin
            m_run = 0; m_pos = 0; m_r = 9; m_pend = 0;
            m_en_prv = 0; m_err = 0;
            return;
        end
        acc   = rif.i_ratio_vld && (m_pend == 0);
        nr    = int'(rif.i_ratio);
        m_err = acc && (nr < 2);
        if (!m_run) begin
            if (m_pend != 0) begin m_r = m_pend; m_pend = 0; end
            if (en) begin m_run = 1; m_pos = 0; end
        end else if (m_pos == m_r - 1) begin
            if (m_pend != 0) begin m_r = m_pend; m_pend = 0; end
            m_pos = 0;
            if (!m_en_prv && !en) m_run = 0;
        end else begin
            m_pos++;
        end
        if (acc && nr >= 2) m_pend = nr;
        m_en_prv = en;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d @%0t", nm, act, exp,
                     $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("m_clk", 32'(o_clk),
                32'(m_run && m_pos < (m_r + 1) / 2));
            chk("m_tick", 32'(o_tick), 32'(m_run && m_pos == 0));
            chk("m_active", 32'(o_active), 32'(m_run));
            chk("m_cur", 32'(o_ratio_cur), 32'(m_r));
            chk("m_rdy", 32'(rif.o_ratio_rdy), 32'(m_pend == 0));
            chk("m_err", 32'(rif.o_ratio_err), 32'(m_err));
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            mdl_step();
            @(negedge clk);
        end
    endtask

    task automatic run_cnt(input int n, output int hi, output int tk);
        hi = 0;
        tk = 0;
        for (int i = 0; i < n; i++) begin
            hi += int'(o_clk);
            tk += int'(o_tick);
            step(1);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (o_active && k < 600) begin
            step(1);
            k++;
        end
        chk("idle_reached", 32'(o_active), 32'd0);
    endtask

    task automatic offer(input logic [7:0] r);
        rif.i_ratio     = r;
        rif.i_ratio_vld = 1;
        step(1);
        rif.i_ratio_vld = 0;
    endtask

    int hi, tk;

    initial begin
        rst             = 1;
        en              = 0;
        rif.i_ratio     = 0;
        rif.i_ratio_vld = 0;
        @(negedge clk);
        step(2);
        chk_on = 1;
        rst    = 0;
        chk("rst_cur", 32'(o_ratio_cur), 32'd9);
        chk("rst_rdy", 32'(rif.o_ratio_rdy), 32'd1);
        chk("rst_clk", 32'(o_clk), 32'd0);
        chk("rst_active", 32'(o_active), 32'd0);

        // start latency and R = 9 shape
        en = 1;
        step(1);
        chk("start_clk", 32'(o_clk), 32'd1);
        chk("start_tick", 32'(o_tick), 32'd1);
        run_cnt(9, hi, tk);
        chk("r9_high", 32'(hi), 32'd5);
        chk("r9_tick", 32'(tk), 32'd1);
        run_cnt(9, hi, tk);
        chk("r9_high2", 32'(hi), 32'd5);

        // ratio 4 accepted at cnt 3
        step(3);
        offer(8'd4);
        chk("r4_rdy_low", 32'(rif.o_ratio_rdy), 32'd0);
        step(4);
        chk("r4_rdy_bnd", 32'(rif.o_ratio_rdy), 32'd0);
        chk("r4_cur_old", 32'(o_ratio_cur), 32'd9);
        step(1);
        chk("r4_cur", 32'(o_ratio_cur), 32'd4);
        chk("r4_rdy_back", 32'(rif.o_ratio_rdy), 32'd1);
        run_cnt(4, hi, tk);
        chk("r4_high", 32'(hi), 32'd2);
        chk("r4_tick", 32'(tk), 32'd1);
        run_cnt(4, hi, tk);
        chk("r4_high2", 32'(hi), 32'd2);

        // switch to 6, then stop at cnt 2
        offer(8'd6);
        step(2);
        step(1);
        chk("r6_cur", 32'(o_ratio_cur), 32'd6);
        step(2);
        en = 0;
        step(1);
        chk("stop_active", 32'(o_active), 32'd1);
        chk("stop_clk_lo", 32'(o_clk), 32'd0);
        step(2);
        chk("stop_last", 32'(o_active), 32'd1);
        step(1);
        chk("stop_idle", 32'(o_active), 32'd0);
        chk("stop_clk", 32'(o_clk), 32'd0);

        // re-raise en mid-period: no gap
        en = 1;
        step(1);
        step(2);
        en = 0;
        step(2);
        en = 1;
        step(1);
        step(1);
        chk("rer_tick", 32'(o_tick), 32'd1);
        run_cnt(6, hi, tk);
        chk("rer_high", 32'(hi), 32'd3);
        // re-raise exactly in the boundary cycle of STOP
        step(4);
        en = 0;
        step(1);
        en = 1;
        step(1);
        chk("bnd_active", 32'(o_active), 32'd1);
        chk("bnd_tick", 32'(o_tick), 32'd1);

        // illegal ratios
        offer(8'd1);
        chk("err1", 32'(rif.o_ratio_err), 32'd1);
        chk("err1_rdy", 32'(rif.o_ratio_rdy), 32'd1);
        offer(8'd0);
        chk("err0", 32'(rif.o_ratio_err), 32'd1);
        chk("err0_cur", 32'(o_ratio_cur), 32'd6);
        step(1);
        chk("err_clear", 32'(rif.o_ratio_err), 32'd0);

        // reset with a ratio pending
        en = 0;
        wait_idle();
        en = 1;
        step(1);
        offer(8'd5);
        step(1);
        chk("rp_rdy", 32'(rif.o_ratio_rdy), 32'd0);
        rst = 1;
        step(1);
        rst = 0;
        chk("rp_clk", 32'(o_clk), 32'd0);
        chk("rp_cur", 32'(o_ratio_cur), 32'd9);
        chk("rp_rdy1", 32'(rif.o_ratio_rdy), 32'd1);
        step(1);
        run_cnt(9, hi, tk);
        chk("rp_high", 32'(hi), 32'd5);
        chk("rp_tick", 32'(tk), 32'd1);
        chk("rp_cur2", 32'(o_ratio_cur), 32'd9);

        // maximum ratio
        en = 0;
        wait_idle();
        offer(8'd255);
        step(1);
        chk("r255_cur", 32'(o_ratio_cur), 32'd255);
        en = 1;
        step(1);
        run_cnt(255, hi, tk);
        chk("r255_high", 32'(hi), 32'd128);
        chk("r255_tick", 32'(tk), 32'd1);
        chk("r255_wrap", 32'(o_tick), 32'd1);
        en = 0;
        wait_idle();
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
